// File: rtl/aes_round_pipe_if.sv
// Valid/ready bus for aes_round_pipe: the transaction input channel and the result channel.
// The master offers round operands and consumes results; the slave is the round block.
interface aes_round_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [127:0]     in_key;
    logic             in_last;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_key, in_last, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_key, in_last, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/aes_round_pipe.sv
// One AES-128 encryption round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey)
// behind a valid/ready handshake, with one or two register stages.
module aes_round_pipe #(
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    aes_round_pipe_if.slave bus
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 00 to 00 on its own.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte index 4*c+r sits at row r, column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_adv;
    logic [127:0]     w_shifted;
    // Operands presented to the output stage, from stage 1 or straight from the input.
    logic             w_rd_valid;
    logic [127:0]     w_rd_state;
    logic [127:0]     w_rd_key;
    logic             w_rd_last;
    logic [TAG_W-1:0] w_rd_tag;
    logic [127:0]     w_result;

    logic             r_out_valid;
    logic [127:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;

    assign w_out_adv = ~r_out_valid | bus.out_ready;
    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_shifted = shift_rows(sub_bytes(bus.in_data));

    generate
        if (STAGES == 2) begin : g_two
            logic             r_s1_valid;
            logic [127:0]     r_s1_state;
            logic [127:0]     r_s1_key;
            logic             r_s1_last;
            logic [TAG_W-1:0] r_s1_tag;

            assign w_in_ready = ~r_s1_valid | w_out_adv;

            // NOTE: sequential state uses <= so every register samples pre-edge values.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_s1_valid <= 1'b0;
                    r_s1_state <= '0;
                    r_s1_key   <= '0;
                    r_s1_last  <= 1'b0;
                    r_s1_tag   <= '0;
                end else if (w_in_ready) begin
                    r_s1_valid <= w_accept;
                    if (w_accept) begin
                        r_s1_state <= w_shifted;
                        r_s1_key   <= bus.in_key;
                        r_s1_last  <= bus.in_last;
                        r_s1_tag   <= bus.in_tag;
                    end
                end
            end

            assign w_rd_valid = r_s1_valid;
            assign w_rd_state = r_s1_state;
            assign w_rd_key   = r_s1_key;
            assign w_rd_last  = r_s1_last;
            assign w_rd_tag   = r_s1_tag;
        end else begin : g_one
            assign w_in_ready = w_out_adv;
            assign w_rd_valid = w_accept;
            assign w_rd_state = w_shifted;
            assign w_rd_key   = bus.in_key;
            assign w_rd_last  = bus.in_last;
            assign w_rd_tag   = bus.in_tag;
        end
    endgenerate

    assign w_result = (w_rd_last ? w_rd_state : mix_columns(w_rd_state)) ^ w_rd_key;

    // NOTE: data registers are reset too, so out_data reads 0 after reset rather than stale state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (w_out_adv) begin
            r_out_valid <= w_rd_valid;
            if (w_rd_valid) begin
                r_out_data <= w_result;
                r_out_tag  <= w_rd_tag;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_aes_round_pipe.sv
// Self-checking bench for aes_round_pipe: one instance with STAGES=1 and one with STAGES=2,
// exercised in turn against a byte-array AES round model with a searched S-box table.
module tb_aes_round_pipe;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [127:0]     data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_pipe_if #(.TAG_W(TAG_W)) bus1 ();
    aes_round_pipe_if #(.TAG_W(TAG_W)) bus2 ();

    aes_round_pipe #(.STAGES(1), .TAG_W(TAG_W)) u_dut1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));
    aes_round_pipe #(.STAGES(2), .TAG_W(TAG_W)) u_dut2 (.CLK(clk), .RST_N(rst_n), .bus(bus2));

    logic             in_valid_a  [2];
    logic [127:0]     in_data_a   [2];
    logic [127:0]     in_key_a    [2];
    logic             in_last_a   [2];
    logic [TAG_W-1:0] in_tag_a    [2];
    logic             out_ready_a [2];

    assign bus1.in_valid  = in_valid_a[0];
    assign bus1.in_data   = in_data_a[0];
    assign bus1.in_key    = in_key_a[0];
    assign bus1.in_last   = in_last_a[0];
    assign bus1.in_tag    = in_tag_a[0];
    assign bus1.out_ready = out_ready_a[0];
    assign bus2.in_valid  = in_valid_a[1];
    assign bus2.in_data   = in_data_a[1];
    assign bus2.in_key    = in_key_a[1];
    assign bus2.in_last   = in_last_a[1];
    assign bus2.in_tag    = in_tag_a[1];
    assign bus2.out_ready = out_ready_a[1];

    function automatic logic in_ready_of(input int k);
        return (k == 0) ? bus1.in_ready : bus2.in_ready;
    endfunction
    function automatic logic out_valid_of(input int k);
        return (k == 0) ? bus1.out_valid : bus2.out_valid;
    endfunction
    function automatic logic [127:0] out_data_of(input int k);
        return (k == 0) ? bus1.out_data : bus2.out_data;
    endfunction
    function automatic logic [TAG_W-1:0] out_tag_of(input int k);
        return (k == 0) ? bus1.out_tag : bus2.out_tag;
    endfunction

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t exp_q[$];
    int   cur = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            for (int i = 0; i < 8; i++)
                r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = r;
        end
    endtask

    function automatic logic [127:0] model_round(input logic [127:0] d, input logic [127:0] key,
                                                 input logic last);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4][4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = sbox_tab[d[127-8*(4*c+r) -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) m[r][c] = t[r][c];
            end else begin
                m[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
                m[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
                m[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
                m[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = m[r][c] ^ key[127-8*(4*c+r) -: 8];
        return res;
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && out_valid_of(cur) === 1'b1 && out_ready_a[cur] === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data_of(cur), e.data);
                check("out_tag", out_tag_of(cur), e.tag);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_rand(input int k, input int idx);
        in_data_a[k]  = {$urandom, $urandom, $urandom, $urandom};
        in_key_a[k]   = {$urandom, $urandom, $urandom, $urandom};
        in_last_a[k]  = idx[0];
        in_tag_a[k]   = idx[TAG_W-1:0];
        in_valid_a[k] = 1'b1;
    endtask

    task automatic directed(input int k, input string name, input logic [127:0] d,
                            input logic [127:0] key, input logic last,
                            input logic [TAG_W-1:0] tag, input logic [127:0] exp);
        int   lat;
        exp_t e;
        @(posedge clk); #1;
        out_ready_a[k] = 1'b1;
        in_data_a[k]   = d;
        in_key_a[k]    = key;
        in_last_a[k]   = last;
        in_tag_a[k]    = tag;
        in_valid_a[k]  = 1'b1;
        #1;
        check({name, "_in_ready"}, in_ready_of(k), 1'b1);
        e.data = exp;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        lat = 1;
        while (out_valid_of(k) !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, k + 1);
        @(negedge clk); #1;
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // hold_len > 0 keeps out_ready low for the first hold_len cycles, starting from an empty pipe.
    task automatic run_stream(input int k, input int n, input int hold_len);
        int           sent;
        int           cyc;
        int           acc_hold;
        int           wait_n;
        bit           have_held;
        bit           accepted;
        logic [127:0] held;
        exp_t         e;
        sent = 0; cyc = 0; acc_hold = 0; have_held = 0; held = '0;
        @(posedge clk); #1;
        drive_rand(k, sent);
        while (sent < n && cyc < 200) begin
            out_ready_a[k] = (cyc >= hold_len);
            #1;
            if (hold_len == 0) check("stream_in_ready", in_ready_of(k), 1'b1);
            if (!out_ready_a[k] && out_valid_of(k)) begin
                if (have_held) check("bp_out_stable", out_data_of(k), held);
                else begin
                    held = out_data_of(k);
                    have_held = 1;
                end
            end
            accepted = in_ready_of(k);
            if (accepted) begin
                e.data = model_round(in_data_a[k], in_key_a[k], in_last_a[k]);
                e.tag  = in_tag_a[k];
                exp_q.push_back(e);
                sent++;
                if (!out_ready_a[k]) acc_hold++;
            end
            @(posedge clk); #1;
            if (accepted) begin
                if (sent < n) drive_rand(k, sent);
                else in_valid_a[k] = 1'b0;
            end
            cyc++;
        end
        in_valid_a[k]  = 1'b0;
        out_ready_a[k] = 1'b1;
        if (hold_len > 0) begin
            check("bp_accepted_in_hold", acc_hold, k + 1);
            wait_n = 0;
            while (exp_q.size() != 0 && wait_n < 50) begin
                @(negedge clk); #1;
                wait_n++;
            end
            check("bp_drain", exp_q.size(), 0);
        end else begin
            repeat (k) @(posedge clk);
            @(negedge clk); #1;
            check("stream_drain", exp_q.size(), 0);
        end
    endtask

    task automatic reset_test(input int k);
        @(posedge clk); #1;
        out_ready_a[k] = 1'b0;
        for (int i = 0; i < k + 1; i++) begin
            drive_rand(k, i);
            @(posedge clk); #1;
        end
        in_valid_a[k] = 1'b0;
        check("full_in_ready", in_ready_of(k), 1'b0);
        check("full_out_valid", out_valid_of(k), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid_of(k), 1'b0);
        check("rst_out_data", out_data_of(k), 128'h0);
        check("rst_out_tag", out_tag_of(k), '0);
        exp_q.delete();
        out_ready_a[k] = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready_of(k), 1'b1);
        directed(k, "post_rst", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 4'h9,
                 128'ha49c7ff2689f352b6b5bea43026a5049);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = '0;
            in_key_a[k]    = '0;
            in_last_a[k]   = 1'b0;
            in_tag_a[k]    = '0;
            out_ready_a[k] = 1'b1;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        build_sbox();
        #2;
        for (int k = 0; k < 2; k++) begin
            check("init_out_valid", out_valid_of(k), 1'b0);
            check("init_out_data", out_data_of(k), 128'h0);
            check("init_out_tag", out_tag_of(k), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check("init_in_ready", in_ready_of(k), 1'b1);

        for (int k = 0; k < 2; k++) begin
            cur = k;
            directed(k, "zero_round", 128'h0, 128'h0, 1'b0, 4'h5, {16{8'h63}});
            directed(k, "sbox_53", {8'h53, 120'h0}, 128'h0, 1'b1, 4'h3, {8'hED, {15{8'h63}}});
            directed(k, "fips_r1", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                     128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 4'hA,
                     128'ha49c7ff2689f352b6b5bea43026a5049);
            directed(k, "fips_r10", 128'heb40f21e592e38848ba113e71bc342d2,
                     128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 4'h6,
                     128'h3925841d02dc09fbdc118597196a0b32);
            run_stream(k, 8, 0);
            run_stream(k, 10, 5);
            reset_test(k);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
